// File: rtl/pipe_skid_stage.sv
// Elastic pipeline-stage register: two-entry skid buffer under valid/ready,
// synchronous flush for bubble insertion, saturating back-pressure counter.
module pipe_skid_stage #(
  parameter int unsigned WIDTH         = 32,
  parameter bit          ZERO_ON_FLUSH = 1'b1,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state;
  state_t           stateNext;
  logic [WIDTH-1:0] mainReg;
  logic [WIDTH-1:0] skidReg;
  logic [CNT_W-1:0] stallCnt;
  logic             xferIn;
  logic             xferOut;
  logic             loadMainIn;
  logic             loadMainSkid;
  logic             loadSkidIn;

  assign xferIn  = in_valid & in_ready;
  assign xferOut = out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext    = state;
    loadMainIn   = 1'b0;
    loadMainSkid = 1'b0;
    loadSkidIn   = 1'b0;
    if (flush) begin
      stateNext = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (xferIn) begin
            loadMainIn = 1'b1;
            stateNext  = ONE;
          end
        end
        ONE: begin
          if (xferIn && xferOut) begin
            loadMainIn = 1'b1;
          end else if (xferIn) begin
            loadSkidIn = 1'b1;
            stateNext  = TWO;
          end else if (xferOut) begin
            stateNext  = EMPTY;
          end
        end
        TWO: begin
          if (xferOut) begin
            loadMainSkid = 1'b1;
            stateNext    = ONE;
          end
        end
        default: stateNext = EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid = (state != EMPTY);
    in_ready  = (state != TWO);
    occupancy = state;
  end

  // Main always holds the older entry; skid only fills from ONE without a drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mainReg <= '0;
      skidReg <= '0;
    end else if (flush) begin
      if (ZERO_ON_FLUSH) begin
        mainReg <= '0;
        skidReg <= '0;
      end
    end else begin
      if (loadMainIn)        mainReg <= in_data;
      else if (loadMainSkid) mainReg <= skidReg;
      if (loadSkidIn)        skidReg <= in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                                    stallCnt <= '0;
    else if (cnt_clr)                                             stallCnt <= '0;
    else if (out_valid && !out_ready && !flush && stallCnt != '1) stallCnt <= stallCnt + 1'b1;
  end

  assign out_data  = mainReg;
  assign stall_cnt = stallCnt;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Randomized and directed bench for pipe_skid_stage; three parameterisations
// share one stimulus stream and one FIFO-queue reference model.
module tb_pipe_skid_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         flush;
  logic         inValid;
  logic         outReady;
  logic         cntClr;
  logic [107:0] inData;

  logic         inReadyA, outValidA;
  logic [1:0]   occA;
  logic [31:0]  outDataA;
  logic [2:0]   stallA;

  logic         inReadyB, outValidB;
  logic [1:0]   occB;
  logic [107:0] outDataB;
  logic [15:0]  stallB;

  logic         inReadyC, outValidC;
  logic [1:0]   occC;
  logic [0:0]   outDataC;
  logic [7:0]   stallC;

  pipe_skid_stage #(.WIDTH(32), .ZERO_ON_FLUSH(1'b1), .CNT_W(3)) dutA (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(inValid), .in_ready(inReadyA), .in_data(inData[31:0]),
    .out_valid(outValidA), .out_ready(outReady), .out_data(outDataA),
    .occupancy(occA), .cnt_clr(cntClr), .stall_cnt(stallA));

  pipe_skid_stage #(.WIDTH(108), .ZERO_ON_FLUSH(1'b0), .CNT_W(16)) dutB (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(inValid), .in_ready(inReadyB), .in_data(inData),
    .out_valid(outValidB), .out_ready(outReady), .out_data(outDataB),
    .occupancy(occB), .cnt_clr(cntClr), .stall_cnt(stallB));

  pipe_skid_stage #(.WIDTH(1), .ZERO_ON_FLUSH(1'b1), .CNT_W(8)) dutC (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(inValid), .in_ready(inReadyC), .in_data(inData[0:0]),
    .out_valid(outValidC), .out_ready(outReady), .out_data(outDataC),
    .occupancy(occC), .cnt_clr(cntClr), .stall_cnt(stallC));

  // Reference model: the stage is a 2-deep FIFO; idle values are what the
  // main register shows when nothing is held (last drained beat, or flush result).
  logic [107:0] q[$];
  logic [107:0] idleZ;
  logic [107:0] idleH;
  int unsigned  cntA, cntB, cntC;
  int           checks = 0;
  int           errors = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic modelClear();
    q.delete();
    idleZ = '0;
    idleH = '0;
    cntA = 0; cntB = 0; cntC = 0;
  endtask

  task automatic modelEdge();
    bit ov;
    bit ir;
    ov = (q.size() > 0);
    ir = (q.size() < 2);
    if (reset) begin
      modelClear();
    end else begin
      if (cntClr) begin
        cntA = 0; cntB = 0; cntC = 0;
      end else if (ov && !outReady && !flush) begin
        if (cntA < 7)     cntA++;
        if (cntB < 65535) cntB++;
        if (cntC < 255)   cntC++;
      end
      if (flush) begin
        if (ov) idleH = q[0];
        idleZ = '0;
        q.delete();
      end else begin
        if (ov && outReady) begin
          idleH = q.pop_front();
          idleZ = idleH;
        end
        if (inValid && ir) q.push_back(inData);
      end
    end
  endtask

  task automatic checkAll(input string tag);
    logic [107:0] eZ;
    logic [107:0] eH;
    int unsigned  n;
    n  = q.size();
    eZ = (n > 0) ? q[0] : idleZ;
    eH = (n > 0) ? q[0] : idleH;
    chk({tag, ".occA"},   128'(occA),      128'(n));
    chk({tag, ".occB"},   128'(occB),      128'(n));
    chk({tag, ".occC"},   128'(occC),      128'(n));
    chk({tag, ".vldA"},   128'(outValidA), 128'(n > 0));
    chk({tag, ".vldB"},   128'(outValidB), 128'(n > 0));
    chk({tag, ".vldC"},   128'(outValidC), 128'(n > 0));
    chk({tag, ".rdyA"},   128'(inReadyA),  128'(n < 2));
    chk({tag, ".rdyB"},   128'(inReadyB),  128'(n < 2));
    chk({tag, ".rdyC"},   128'(inReadyC),  128'(n < 2));
    chk({tag, ".dataA"},  128'(outDataA),  128'(eZ[31:0]));
    chk({tag, ".dataB"},  128'(outDataB),  128'(eH));
    chk({tag, ".dataC"},  128'(outDataC),  128'(eZ[0]));
    chk({tag, ".stallA"}, 128'(stallA),    128'(cntA));
    chk({tag, ".stallB"}, 128'(stallB),    128'(cntB));
    chk({tag, ".stallC"}, 128'(stallC),    128'(cntC));
  endtask

  task automatic step(input string tag);
    modelEdge();
    @(posedge clk);
    #1;
    checkAll(tag);
  endtask

  task automatic drive(input bit v, input logic [107:0] d, input bit r, input bit f, input bit c);
    inValid  = v;
    inData   = d;
    outReady = r;
    flush    = f;
    cntClr   = c;
  endtask

  initial begin
    logic [127:0] rnd;
    reset = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    modelClear();
    #3;
    checkAll("rstInit");
    step("rstEdge");
    reset = 1'b0;

    // Streaming: one beat per cycle, occupancy stays at 1.
    drive(1'b1, 108'h11, 1'b1, 1'b0, 1'b0); step("stream1");
    chk("stream1.const", 128'(outDataA), 128'h11);
    drive(1'b1, 108'h22, 1'b1, 1'b0, 1'b0); step("stream2");
    chk("stream2.const", 128'(outDataA), 128'h22);
    drive(1'b1, 108'h33, 1'b1, 1'b0, 1'b0); step("stream3");
    chk("stream3.const", 128'(outDataA), 128'h33);
    chk("stream3.occ", 128'(occA), 128'd1);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0); step("streamDrain");

    // Back-pressure: fill to TWO, then drain in order.
    drive(1'b1, 108'hA, 1'b0, 1'b0, 1'b0); step("bp1");
    drive(1'b1, 108'hB, 1'b0, 1'b0, 1'b0); step("bp2");
    chk("bp2.occ", 128'(occA), 128'd2);
    chk("bp2.rdy", 128'(inReadyA), 128'd0);
    drive(1'b1, 108'hC, 1'b0, 1'b0, 1'b0); step("bpStall");
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0); step("bpOut1");
    chk("bpOut1.const", 128'(outDataA), 128'hB);
    step("bpOut2");
    chk("bpOut2.occ", 128'(occA), 128'd0);

    // Flush from TWO with a simultaneous offer and drain.
    drive(1'b1, 108'h71, 1'b0, 1'b0, 1'b0); step("fl1");
    drive(1'b1, 108'h72, 1'b0, 1'b0, 1'b0); step("fl2");
    drive(1'b1, 108'h55, 1'b1, 1'b1, 1'b0); step("flush");
    chk("flush.dataA", 128'(outDataA), 128'd0);
    chk("flush.dataB", 128'(outDataB), 128'h71);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0); step("postFlush");

    // Saturation of the 3-bit counter, then clear inside a stalled cycle.
    drive(1'b1, 108'h5A, 1'b0, 1'b0, 1'b0); step("satFill");
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    cntClr = 1'b1; step("satClr0");
    cntClr = 1'b0;
    for (int unsigned i = 0; i < 10; i++) step("satStall");
    chk("sat.held", 128'(stallA), 128'd7);
    cntClr = 1'b1; step("satClr");
    chk("satClr.zero", 128'(stallA), 128'd0);
    cntClr = 1'b0; step("satResume1");
    chk("satResume1.one", 128'(stallA), 128'd1);
    step("satResume2");

    // Asynchronous reset while holding two entries.
    drive(1'b1, 108'h91, 1'b0, 1'b0, 1'b0); step("ar1");
    chk("ar1.occ", 128'(occA), 128'd2);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    modelClear();
    #1;
    checkAll("asyncRst");
    step("asyncRstEdge");
    reset = 1'b0;
    drive(1'b1, 108'h3C, 1'b1, 1'b0, 1'b0); step("firstAfterRst");

    // Random traffic across all three parameterisations.
    for (int unsigned i = 0; i < 3000; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      drive($urandom_range(0, 3) != 0, rnd[107:0], $urandom_range(0, 2) != 0,
            $urandom_range(0, 31) == 0, $urandom_range(0, 63) == 0);
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
